// File: rtl/d_cache_wb_pkg.sv
// Shared types and helpers for the d_cache_wb write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2
    } state_e;

    // Replace only the bytes whose enable bit is set.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  wsel
    );
        logic [31:0] merged;
        merged = old_w;
        for (int i = 0; i < 4; i++) begin
            if (wsel[i]) merged[8*i +: 8] = new_w[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/d_cache_wb_if.sv
// CPU-side and memory-side buses of d_cache_wb; slave = cache view, master = CPU/memory view.
interface d_cache_wb_if #(
    parameter int A_WIDTH = 32
);
    // CPU: request held stable while p_strobe=1 until the cycle p_ready=1 (that cycle completes it).
    // Memory: each beat held stable while m_strobe=1 until the cycle m_ready=1 (accepted at that edge).
    logic [A_WIDTH-1:0] p_a;
    logic [31:0]        p_dout;
    logic [3:0]         p_wsel;
    logic               p_strobe;
    logic               p_rw;
    logic [31:0]        p_din;
    logic               p_ready;

    logic [A_WIDTH-1:0] m_a;
    logic [31:0]        m_din;
    logic               m_strobe;
    logic               m_rw;
    logic [31:0]        m_dout;
    logic               m_ready;

    modport slave (
        input  p_a, p_dout, p_wsel, p_strobe, p_rw, m_dout, m_ready,
        output p_din, p_ready, m_a, m_din, m_strobe, m_rw
    );

    modport master (
        output p_a, p_dout, p_wsel, p_strobe, p_rw, m_dout, m_ready,
        input  p_din, p_ready, m_a, m_din, m_strobe, m_rw
    );
endinterface

// File: rtl/d_cache_wb_line_ram.sv
// Line data array: one byte-enabled write port, two asynchronous word read ports on the same line.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int C_INDEX  = 6,
    parameter int C_OFFSET = 2
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [C_INDEX-1:0]  idx_i,
    input  logic [C_OFFSET-1:0] wword_i,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          wbe_i,
    input  logic [C_OFFSET-1:0] rword_a_i,
    output logic [31:0]         rdata_a_o,
    input  logic [C_OFFSET-1:0] rword_b_i,
    output logic [31:0]         rdata_b_o
);
    localparam int DEPTH = 1 << (C_INDEX + C_OFFSET);

    logic [31:0] mem_q [DEPTH];

    assign rdata_a_o = mem_q[{idx_i, rword_a_i}];
    assign rdata_b_o = mem_q[{idx_i, rword_b_i}];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[{idx_i, wword_i}] <= byte_merge(mem_q[{idx_i, wword_i}], wdata_i, wbe_i);
    end
endmodule

// File: rtl/d_cache_wb.sv
// Direct-mapped write-back, write-allocate data cache with multi-word lines.
// Define DCACHE_STATS_EN to add the hit_cnt / miss_cnt counter outputs.
module d_cache_wb
    import dcache_pkg::*;
#(
    parameter int A_WIDTH  = 32,
    parameter int C_INDEX  = 6,
    parameter int C_OFFSET = 2
) (
    input  logic        clk,
    input  logic        rst,
    d_cache_wb_if.slave bus,
    output logic [1:0]  dbg_state_o
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;
    localparam int LINES   = 1 << C_INDEX;

    state_e              state_q;
    logic [C_OFFSET-1:0] beat_q;
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [T_WIDTH-1:0]  tag_arr_q [LINES];

    logic [T_WIDTH-1:0]  tag;
    logic [C_INDEX-1:0]  idx;
    logic [C_OFFSET-1:0] word;
    logic                unused_p_a_lsb;

    assign tag            = bus.p_a[A_WIDTH-1 -: T_WIDTH];
    assign idx            = bus.p_a[C_INDEX+C_OFFSET+1 : C_OFFSET+2];
    assign word           = bus.p_a[C_OFFSET+1 : 2];
    assign unused_p_a_lsb = ^bus.p_a[1:0];

    logic hit, last_beat, hit_acc, miss_start, refill_beat, ram_we;
    logic [31:0] rd_cpu, rd_wb;

    assign hit         = valid_q[idx] && (tag_arr_q[idx] == tag);
    assign last_beat   = (beat_q == {C_OFFSET{1'b1}});
    assign hit_acc     = (state_q == S_IDLE) && bus.p_strobe && hit;
    assign miss_start  = (state_q == S_IDLE) && bus.p_strobe && !hit;
    assign refill_beat = (state_q == S_REFILL) && bus.m_ready;
    assign ram_we      = refill_beat || (hit_acc && bus.p_rw);

    // Refill beats own the write port; otherwise it carries CPU write hits.
    dcache_line_ram #(
        .C_INDEX  (C_INDEX),
        .C_OFFSET (C_OFFSET)
    ) u_line_ram (
        .clk_i     (clk),
        .we_i      (ram_we),
        .idx_i     (idx),
        .wword_i   (refill_beat ? beat_q : word),
        .wdata_i   (refill_beat ? bus.m_dout : bus.p_dout),
        .wbe_i     (refill_beat ? 4'hF : bus.p_wsel),
        .rword_a_i (word),
        .rdata_a_o (rd_cpu),
        .rword_b_i (beat_q),
        .rdata_b_o (rd_wb)
    );

    assign bus.p_ready  = hit_acc;
    assign bus.p_din    = rd_cpu;
    assign bus.m_strobe = (state_q != S_IDLE);
    assign bus.m_rw     = (state_q == S_WB);
    assign bus.m_din    = rd_wb;
    assign bus.m_a      = (state_q == S_WB) ? {tag_arr_q[idx], idx, beat_q, 2'b00}
                                            : {tag, idx, beat_q, 2'b00};
    assign dbg_state_o  = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit_acc && bus.p_rw) dirty_q[idx] <= 1'b1;
                    if (miss_start) begin
                        beat_q  <= '0;
                        state_q <= (valid_q[idx] && dirty_q[idx]) ? S_WB : S_REFILL;
                    end
                end
                S_WB: begin
                    // beat_q wraps to zero on the last beat, ready for the refill.
                    if (bus.m_ready) begin
                        beat_q <= beat_q + C_OFFSET'(1);
                        if (last_beat) state_q <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (bus.m_ready) begin
                        beat_q <= beat_q + C_OFFSET'(1);
                        if (last_beat) begin
                            valid_q[idx] <= 1'b1;
                            dirty_q[idx] <= 1'b0;
                            state_q      <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && refill_beat && last_beat) tag_arr_q[idx] <= tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_acc)    hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: doc/d_cache_wb.md
Name: d_cache_wb

Overview:
- Parametrised successor to the word-granular write-through data cache.
- Direct-mapped, multi-word lines, write-back, write-allocate, byte-enable writes.
- A three-state FSM performs victim write-back and line refill as word beats over the existing single-word strobe/ready memory port.
- Sits between the CPU data port and the SRAM-style memory bus. Keeps the p_*/m_* port split.

Parameters:
- A_WIDTH, 32, byte address width.
- C_INDEX, 6, log2 of number of lines.
- C_OFFSET, 2, log2 of words per line; legal range 1..4.
- Derived: T_WIDTH = A_WIDTH-C_INDEX-C_OFFSET-2; LINE_WORDS = 1<<C_OFFSET.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active high.
- p_a  in  A_WIDTH  CPU byte address, word-aligned.
- p_dout  in  32  CPU write data.
- p_wsel  in  4  byte enables for writes; ignored on reads.
- p_strobe  in  1  request valid.
- p_rw  in  1  0 read, 1 write.
- p_din  out  32  read data.
- p_ready  out  1  request completes this cycle.
- m_a  out  A_WIDTH  memory word address for the current beat.
- m_din  out  32  memory write data.
- m_strobe  out  1  beat request.
- m_rw  out  1  0 read beat, 1 write beat.
- m_dout  in  32  memory read data.
- m_ready  in  1  beat accepted or complete.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on rst.
- Reset, at the clk edge with rst=1:
  - state=IDLE, beat counter=0, all valid and dirty bits=0.
  - m_strobe=0, m_rw=0, p_ready=0.
  - Data and tag arrays are not reset.
  - Reset during WB or REFILL aborts immediately; dirty data is discarded.
- Address split: tag=p_a[A_WIDTH-1:C_INDEX+C_OFFSET+2], index=p_a[C_INDEX+C_OFFSET+1:C_OFFSET+2], word=p_a[C_OFFSET+1:2].
- hit = valid[index] & (tag_arr[index]==tag). Array reads are asynchronous.
- States: IDLE, WB, REFILL.
- IDLE, p_strobe & hit:
  - p_ready=1 in the same cycle.
  - Read: p_din = data[index][word].
  - Write: bytes with p_wsel[i]=1 are merged into data[index][word] at the clk edge, and dirty[index] is set.
  - No memory traffic.
- IDLE, p_strobe & miss: p_ready=0. Go to WB if valid&dirty, else go to REFILL. Beat counter=0.
- WB:
  - m_strobe=1, m_rw=1.
  - m_a = {tag_arr[index], index, beat, 2'b00}; m_din = data[index][beat].
  - On m_ready, beat increments. On the last beat with m_ready, go to REFILL with beat=0.
- REFILL:
  - m_strobe=1, m_rw=0.
  - m_a = {tag, index, beat, 2'b00}.
  - On m_ready, m_dout is written to data[index][beat].
  - On the last beat: tag_arr=tag, valid=1, dirty=0, go to IDLE.
  - The following cycle hits and completes normally, giving write-allocate.
- Miss latency:
  - Clean miss: LINE_WORDS beats + 1 cycle.
  - Dirty miss: 2*LINE_WORDS beats + 1 cycle.
- Memory handshake:
  - m_a, m_rw and m_din are stable while m_strobe=1 and m_ready=0.
  - m_strobe drops only after the final beat.
  - No idle cycle between WB and REFILL beats is required; m_strobe may stay high.
- CPU rules:
  - The CPU holds p_a, p_rw, p_dout and p_wsel stable until p_ready.
  - If p_strobe drops during WB/REFILL, the line operation still completes and the FSM returns to IDLE without p_ready.
- p_din:
  - Outside a read hit, p_din = data[index][word] (don't-care).
  - p_ready is never asserted outside IDLE.
- Write with p_wsel=0 on a hit: completes, and dirty is still set.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each IDLE cycle with p_strobe&hit&p_ready.
  - miss_cnt increments on each IDLE→WB or IDLE→REFILL transition.
  - Both cleared by rst and wrap modulo 2^32.
  - The post-refill hit counts as a hit.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state encoding localparams S_IDLE=2'd0, S_WB=2'd1, S_REFILL=2'd2.
  - a byte-merge function (old word, new word, wsel → merged word).
- One natural sub-module: dcache_line_ram, holding the data array with async read, write port and byte enables.
- Tags, valid, dirty and the FSM stay in the top level.

Test Plan:
- Reset, then read 0x0000_0040 with m_ready after 2 cycles per beat:
  - 4 read beats at 0x40, 0x44, 0x48, 0x4C.
  - Then p_ready with p_din = memory word at 0x40.
  - Re-read 0x44 → p_ready same cycle, m_strobe=0.
- Write hit at 0x44, p_dout=0xDEADBEEF, p_wsel=4'b0011, old value 0x11223344 → later read returns 0x1122BEEF, no memory writes.
- Conflict read at 0x0000_1040 (same index, different tag) after the dirty write:
  - 4 write beats 0x40..0x4C carrying the line, with 0x1122BEEF at 0x44.
  - Then 4 read beats 0x1040..0x104C, then p_ready.
- m_ready held low for 10 cycles mid-WB → m_a and m_din stay constant, beat count unchanged.
- Assert rst during REFILL beat 2:
  - Next cycle m_strobe=0, state IDLE.
  - Re-read of the same address misses and refills fully.
- With DCACHE_STATS_EN defined, run the scenarios above → hit_cnt and miss_cnt equal scoreboard-computed totals.
  - Without the macro, the build has no hit_cnt or miss_cnt ports.
